// File: rtl/resource_arb_pkg.sv
// Shared types and constants for the round-robin resource arbiter.
package resource_arb_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int RESOURCE_OFFSET = 10;
  // Requester ids are carried at the widest supported size (16 requesters).
  localparam int ID_MAX_W        = 4;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } pipe_stage_t;

endpackage

// File: rtl/resource_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after last_grant wins.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_grant
);

  logic [ID_W-1:0] idx;

  // Scan NUM_REQ positions starting one past the previous winner, wrapping.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_grant && eligible[idx]) begin
        any_grant   = 1'b1;
        winner      = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/resource_arbiter.sv
// Shares one externally connected 2-cycle resource between NUM_REQ requesters,
// tracking each accepted request so its result returns to the issuer.
module resource_arbiter
  import resource_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_mask,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resource_rst,
  output logic [DATA_W-1:0]         resource_input,
  input  logic [DATA_W-1:0]         resource_output,
  output logic                      busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    last_grant;
  logic               any_grant;
  logic [DATA_W-1:0]  win_data;
  pipe_stage_t        s1;
  pipe_stage_t        s2;

  assign eligible     = req_valid & req_mask & {NUM_REQ{enable & reset}};
  assign req_ready    = grant;
  assign resource_rst = ~reset;
  assign resp_data    = resource_output;
  assign busy         = s1.valid | s2.valid;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .eligible  (eligible),
    .last_grant(last_grant),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // Select the granted requester's word; grant is one-hot or zero.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Decode the stage-2 id into the one-hot response strobe.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = s2.valid & reset & (s2.id == ID_MAX_W'(i));
    end
  end

  // Launch accepted words into the resource and shadow its two-stage pipeline.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resource_input <= '0;
      last_grant     <= '0;
      s1             <= '0;
      s2             <= '0;
    end else begin
      if (any_grant) begin
        resource_input <= win_data;
        last_grant     <= winner;
      end
      s1.valid <= any_grant;
      s1.id    <= ID_MAX_W'(winner);
      s2       <= s1;
    end
  end

endmodule

// File: tb/tb_resource_arbiter.sv
// Directed bench for resource_arbiter with a behavioural 2-cycle resource.
module tb_resource_arbiter;
  import resource_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req_mask;
  logic [3:0]  req_valid;
  logic [31:0] dw [4];
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [31:0] resp_data;
  logic        resource_rst;
  logic [31:0] resource_input;
  logic [31:0] resource_output;
  logic        busy;

  int checks = 0;
  int errors = 0;

  assign req_data = {dw[3], dw[2], dw[1], dw[0]};

  always #5 clk = ~clk;

  // Behavioural resource: registered input + offset, held in reset by the arbiter.
  always @(posedge clk) begin
    if (resource_rst) resource_output <= '0;
    else              resource_output <= resource_input + 32'(RESOURCE_OFFSET);
  end

  resource_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .req_mask       (req_mask),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resource_rst   (resource_rst),
    .resource_input (resource_input),
    .resource_output(resource_output),
    .busy           (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; req_mask = 4'hF; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) dw[i] = 32'h11 * (i + 1);
    tick(); tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp got %b want 0000", resp_valid); end
    checks++; if (resource_rst !== 1'b1) begin errors++; $display("FAIL reset_rst got %b want 1", resource_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (resource_input !== 32'h0) begin errors++; $display("FAIL reset_input got %h want 0", resource_input); end
    req_valid = '0;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (resource_rst !== 1'b0) begin errors++; $display("FAIL release_rst got %b want 0", resource_rst); end
  endtask

  task automatic test_single();
    tick();
    req_valid = 4'b0100; dw[2] = 32'h5;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (resource_input !== 32'h5) begin errors++; $display("FAIL single_input got %h want 5", resource_input); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_early got %b want 0000", resp_valid); end
    tick();
    #1;
    checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL single_resp got %b want 0100", resp_valid); end
    checks++; if (resp_data !== 32'hF) begin errors++; $display("FAIL single_data got %h want f", resp_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g [5];
    logic [31:0] exp_d [5];
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_d = '{32'h10A, 32'h20A, 32'h30A, 32'h00A, 32'h10A};
    do_reset();
    for (int i = 0; i < 4; i++) dw[i] = 32'h100 * i;
    for (int c = 0; c < 7; c++) begin
      tick();
      req_valid = (c < 5) ? 4'hF : 4'h0;
      #1;
      if (c < 5) begin
        checks++; if (req_ready !== exp_g[c]) begin errors++; $display("FAIL rr_grant c%0d got %b want %b", c, req_ready, exp_g[c]); end
      end
      if (c >= 2) begin
        checks++; if (resp_valid !== exp_g[c-2]) begin errors++; $display("FAIL rr_resp c%0d got %b want %b", c, resp_valid, exp_g[c-2]); end
        checks++; if (resp_data !== exp_d[c-2]) begin errors++; $display("FAIL rr_data c%0d got %h want %h", c, resp_data, exp_d[c-2]); end
      end
    end
  endtask

  task automatic test_mask();
    logic [3:0] exp_g [8];
    exp_g = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick();
      req_valid = 4'hF;
      req_mask  = (c < 4) ? 4'b1011 : 4'b1010;
      #1;
      checks++; if (req_ready !== exp_g[c]) begin errors++; $display("FAIL mask_grant c%0d got %b want %b", c, req_ready, exp_g[c]); end
    end
    tick();
    req_valid = '0; req_mask = 4'hF;
    tick(); tick();
  endtask

  task automatic test_overflow();
    do_reset();
    tick();
    req_valid = 4'b0001; dw[0] = 32'hFFFF_FFFA;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ovf_ready got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    #1;
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL ovf_resp got %b want 0001", resp_valid); end
    checks++; if (resp_data !== 32'h4) begin errors++; $display("FAIL ovf_data got %h want 4", resp_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    req_valid = 4'b0010; dw[1] = 32'h55;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_ready got %b want 0010", req_ready); end
    tick();
    req_valid = '0; reset = 1'b0;
    #1;
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_c1_resp got %b want 0000", resp_valid); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_c2_resp got %b want 0000", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (resource_input !== 32'h0) begin errors++; $display("FAIL rmid_input got %h want 0", resource_input); end
    tick();
    #1;
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_c3_resp got %b want 0000", resp_valid); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    dw[0] = 32'h1; dw[1] = 32'h2;
    tick();
    req_valid = 4'b0011; enable = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL en_c0_ready got %b want 0010", req_ready); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL en_c1_ready got %b want 0001", req_ready); end
    tick();
    enable = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL en_c2_ready got %b want 0000", req_ready); end
    checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL en_c2_resp got %b want 0010", resp_valid); end
    checks++; if (resp_data !== 32'hC) begin errors++; $display("FAIL en_c2_data got %h want c", resp_data); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL en_c3_ready got %b want 0000", req_ready); end
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL en_c3_resp got %b want 0001", resp_valid); end
    checks++; if (resp_data !== 32'hB) begin errors++; $display("FAIL en_c3_data got %h want b", resp_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_c3_busy got %b want 1", busy); end
    tick();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_c4_busy got %b want 0", busy); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL en_c4_resp got %b want 0000", resp_valid); end
    req_valid = '0; enable = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; req_mask = 4'hF; req_valid = '0;
    for (int i = 0; i < 4; i++) dw[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_overflow();
    test_reset_mid();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resource_arbiter.md
Name: resource_arbiter

Overview:
- Round-robin arbiter that shares one shared_resource instance between NUM_REQ requesters.
- Accepts one request per cycle and drives the winning input word into the resource.
- Tracks the 2-cycle resource pipeline and routes each result (input + 10) back to the requester that issued it.
- Sits between requester blocks and the resource. It also owns the resource's reset, and carries a per-requester access mask used for isolation experiments.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 32, request/response data width; must match the resource width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- enable  input  1  1 = grants allowed; 0 = no new grants, in-flight requests complete.
- req_mask  input  NUM_REQ  bit i = 1 permits requester i; masked requesters are never granted.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_data  input  NUM_REQ*DATA_W  flattened request words; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot (or zero) grant; a request is accepted when req_valid[i] & req_ready[i].
- resp_valid  output  NUM_REQ  one-hot response strobe; high for exactly 1 cycle per accepted request.
- resp_data  output  DATA_W  response word, meaningful only while any resp_valid bit is high.
- resource_rst  output  1  active-high reset to the resource; equals ~reset (combinational).
- resource_input  output  DATA_W  word driven into the resource.
- resource_output  input  DATA_W  resource result, registered by the resource.
- busy  output  1  high while any accepted request has not yet produced its response.

Behaviour:
- Eligibility: eligible[i] = req_valid[i] & req_mask[i] & enable & reset.
- req_ready is combinational from eligible and the round-robin pointer.
  - Exactly one bit is set when any requester is eligible; otherwise all bits are 0.
  - req_ready never depends on resp_valid; the pipeline has no backpressure.
- Round-robin: register last_grant (log2 NUM_REQ bits, reset 0).
  - Search starts at index last_grant+1 (mod NUM_REQ), wrapping, and the first eligible requester wins.
  - last_grant updates to the winner only on an accepted cycle; otherwise it holds.
- Pipeline, with acceptance in cycle T:
  - Edge ending T: resource_input <= winning req_data; s1_valid <= 1; s1_id <= winner.
  - Edge ending T+1: the resource captures resource_input + 10; s2_valid <= s1_valid; s2_id <= s1_id.
  - Cycle T+2: resp_valid[s2_id] = s2_valid; resp_data = resource_output (combinational pass-through).
  - Latency is 2 cycles from accept to response. Throughput is 1 per cycle, and back-to-back accepts give back-to-back responses in accept order.
- resource_input holds its last value when nothing is accepted, so the resource output is stable but ignored.
- Arithmetic is performed in the resource modulo 2^DATA_W; the arbiter passes data unmodified. 0xFFFF_FFFA returns 0x0000_0004.
- busy = s1_valid | s2_valid.
- Reset (reset == 0 at a rising edge):
  - resource_input <= 0, s1/s2 valid <= 0, ids <= 0, last_grant <= 0.
  - req_ready = 0 and resp_valid = 0 while reset is low.
  - resource_rst = 1 while reset is low.
  - Reset mid-operation discards all in-flight requests; no response is ever issued for them.
- enable falling with requests in flight: no new grants; the in-flight responses are still delivered on schedule.
- Mask change takes effect in the same cycle (combinational). A request already accepted completes even if its mask bit drops afterward.
- Simultaneous events: a new accept and a response delivery in the same cycle are independent and both occur.
- A requester holding req_valid continuously while others also request is granted at least once every NUM_REQ accepted cycles; no starvation.

Decomposition:
- Package resource_arb_pkg:
  - DATA_W default.
  - RESOURCE_OFFSET = 10, for the bench model.
  - typedef pipe_stage_t {valid, id}.
- Sub-module rr_pick (combinational):
  - inputs: eligible vector, last_grant.
  - outputs: one-hot grant, encoded winner index, any_grant.
- Top level: instantiates rr_pick, holds the registers, and instantiates no resource (the resource is connected externally).

Test Plan:
- Single request: reset low 2 cycles, then release; req_valid[2] with data 0x0000_0005 in cycle 0 -> req_ready = 0b0100 in cycle 0; resource_input = 5 after the edge; resp_valid = 0b0100 with resp_data = 0x0000_000F in cycle 2.
- Round-robin fairness: all 4 requesters valid continuously, data = index*0x100, last_grant = 0 -> grants 1,2,3,0,1 on consecutive cycles; responses 0x10A, 0x20A, 0x30A, 0x00A arrive in the same order 2 cycles later.
- Mask: req_mask = 0b1011, all valid -> requester 2 is never granted over 8 cycles; grants cycle 1,3,0,1,...; clearing mask bit 0 mid-stream removes requester 0 from the next cycle.
- Wrap and overflow: requester 0 data 0xFFFF_FFFA -> resp_data = 0x0000_0004 two cycles later.
- Reset mid-flight: accept in cycle 0, reset low in cycle 1 -> no resp_valid in cycle 2; busy = 0 and resource_input = 0 after reset.
- enable drop: accepts in cycles 0 and 1, enable = 0 from cycle 2 with requests still valid -> responses in cycles 2 and 3, req_ready = 0 from cycle 2, busy falls after cycle 3.
